audio_stream_player: RTL and testbench

AUDIO_STREAM_PLAYER -- requirements
Module: audio_stream_player

---
 rtl/audio_stream_player.sv | 133 +++++++++++++
 tb/tb_audio_stream_player.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_stream_player.sv
// audio_stream_player: FIFO-buffered PCM samples played out as PWM at a fixed sample rate.
// Build option: define AUDIO_STREAM_PLAYER_VOLUME_EN to apply the 'volume' right shift.
//
// state | meaning
// IDLE  | playback off, buffer retained
// PRIME | enabled, waiting for PRIME_LEVEL samples
// PLAY  | rate ticks pop samples into the PWM stage
module audio_stream_player #(
    parameter int SAMPLE_W    = 8,
    parameter int DEPTH_LOG2  = 11,
    parameter int RATE_DIV    = 2083,
    parameter int PRIME_LEVEL = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  flush,
    input  logic [SAMPLE_W-1:0]   wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [2:0]            volume,
    output logic                  pwm_out,
    output logic [DEPTH_LOG2:0]   fill_count,
    output logic                  underflow,
    output logic                  playing
);
    localparam int DEPTH    = 1 << DEPTH_LOG2;
    localparam int RATE_EFF = (RATE_DIV < 2) ? 2 : RATE_DIV;
    localparam int RATE_W   = $clog2(RATE_EFF);
    localparam logic [RATE_W-1:0]     RATE_MAX  = RATE_W'(RATE_EFF - 1);
    localparam logic [DEPTH_LOG2:0]   FULL_CNT  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   PRIME_CNT = (DEPTH_LOG2+1)'(PRIME_LEVEL);
    localparam logic [SAMPLE_W-1:0]   MIDSCALE  = {1'b1, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_t;

    state_t                  state, state_next;
    logic [SAMPLE_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
    logic [RATE_W-1:0]       rate_cnt;
    logic [SAMPLE_W-1:0]     cur_sample;
    logic [SAMPLE_W-1:0]     pwm_cnt;
    logic [SAMPLE_W-1:0]     rd_sample;
    logic [SAMPLE_W-1:0]     scaled_sample;
    logic                    tick, push, pop;

    assign wr_ready  = (fill_count < FULL_CNT);
    assign playing   = (state == PLAY);
    assign tick      = (state == PLAY) && (rate_cnt == RATE_MAX);
    // Pop decisions use the registered count, so a same-cycle write never bypasses.
    assign push      = wr_valid && wr_ready && !flush;
    assign pop       = tick && (fill_count != '0) && !flush;
    assign rd_sample = mem[rd_ptr];

`ifdef AUDIO_STREAM_PLAYER_VOLUME_EN
    assign scaled_sample = rd_sample >> volume;
`else
    logic unused_volume;
    assign unused_volume = ^volume;
    assign scaled_sample = rd_sample;
`endif

    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = PRIME;
                PRIME:   if (!flush && fill_count >= PRIME_CNT) state_next = PLAY;
                PLAY:    if (flush) state_next = PRIME;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
            underflow  <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
            underflow  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill_count <= fill_count + 1'b1;
                2'b01:   fill_count <= fill_count - 1'b1;
                default: fill_count <= fill_count;
            endcase
            if (tick && fill_count == '0) underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rate_cnt   <= '0;
            cur_sample <= MIDSCALE;
        end else if (state != PLAY || state_next != PLAY) begin
            rate_cnt   <= '0;
            cur_sample <= MIDSCALE;
        end else if (tick) begin
            rate_cnt   <= '0;
            cur_sample <= pop ? scaled_sample : MIDSCALE;
        end else begin
            rate_cnt   <= rate_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            pwm_out <= (pwm_cnt < cur_sample);
        end
    end
endmodule

// File: tb/tb_audio_stream_player.sv
// Directed bench for audio_stream_player at SAMPLE_W=8, DEPTH_LOG2=4, RATE_DIV=4, PRIME_LEVEL=2.
module tb_audio_stream_player;
    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       enable = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [2:0] volume = '0;
    logic       pwm_out;
    logic [4:0] fill_count;
    logic       underflow;
    logic       playing;

    int vectors = 0;
    int errors  = 0;

    audio_stream_player #(
        .SAMPLE_W(8), .DEPTH_LOG2(4), .RATE_DIV(4), .PRIME_LEVEL(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .volume(volume), .pwm_out(pwm_out), .fill_count(fill_count),
        .underflow(underflow), .playing(playing)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable = 1'b0; flush = 1'b0; wr_valid = 1'b0; volume = '0;
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (fill_count !== 5'd0 || wr_ready !== 1'b1 || underflow !== 1'b0 ||
            playing !== 1'b0 || pwm_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: fill=%0d rdy=%b uf=%b play=%b pwm=%b, want 0 1 0 0 0",
                     fill_count, wr_ready, underflow, playing, pwm_out);
        end
        vectors++;
        if (dut.cur_sample !== 8'h80) begin
            errors++;
            $display("FAIL reset_cur_sample: got %h want 80", dut.cur_sample);
        end
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_play_underflow();
        do_reset();
        enable = 1'b1; wr_valid = 1'b1; wr_data = 8'h10;
        cyc(1);
        wr_data = 8'h20;
        cyc(1);
        wr_valid = 1'b0;
        vectors++;
        if (playing !== 1'b0 || fill_count !== 5'd2) begin
            errors++;
            $display("FAIL prime_wait: play=%b fill=%0d, want 0 2", playing, fill_count);
        end
        cyc(1);
        vectors++;
        if (playing !== 1'b1) begin
            errors++;
            $display("FAIL play_rise: got %b want 1", playing);
        end
        cyc(3);
        vectors++;
        if (dut.cur_sample !== 8'h80 || fill_count !== 5'd2) begin
            errors++;
            $display("FAIL pre_tick: cur=%h fill=%0d, want 80 2", dut.cur_sample, fill_count);
        end
        cyc(1);
        vectors++;
        if (dut.cur_sample !== 8'h10 || fill_count !== 5'd1) begin
            errors++;
            $display("FAIL tick1: cur=%h fill=%0d, want 10 1", dut.cur_sample, fill_count);
        end
        cyc(3);
        vectors++;
        if (dut.cur_sample !== 8'h10) begin
            errors++;
            $display("FAIL hold1: cur=%h want 10", dut.cur_sample);
        end
        cyc(1);
        vectors++;
        if (dut.cur_sample !== 8'h20 || fill_count !== 5'd0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL tick2: cur=%h fill=%0d uf=%b, want 20 0 0", dut.cur_sample, fill_count, underflow);
        end
        cyc(4);
        vectors++;
        if (dut.cur_sample !== 8'h80 || underflow !== 1'b1 || playing !== 1'b1) begin
            errors++;
            $display("FAIL underrun: cur=%h uf=%b play=%b, want 80 1 1", dut.cur_sample, underflow, playing);
        end
        cyc(8);
        vectors++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow_sticky: got %b want 1", underflow);
        end
        flush = 1'b1; wr_valid = 1'b1; wr_data = 8'h55;
        cyc(1);
        flush = 1'b0; wr_valid = 1'b0;
        vectors++;
        if (underflow !== 1'b0 || fill_count !== 5'd0 || playing !== 1'b0) begin
            errors++;
            $display("FAIL flush: uf=%b fill=%0d play=%b, want 0 0 0", underflow, fill_count, playing);
        end
        enable = 1'b0;
        cyc(1);
    endtask

    task automatic test_full_and_wrap();
        do_reset();
        wr_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            wr_data = 8'(i + 1);
            cyc(1);
        end
        vectors++;
        if (fill_count !== 5'd15 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill15: fill=%0d rdy=%b, want 15 1", fill_count, wr_ready);
        end
        wr_data = 8'h10;
        cyc(1);
        vectors++;
        if (fill_count !== 5'd16 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL full: fill=%0d rdy=%b, want 16 0", fill_count, wr_ready);
        end
        wr_data = 8'hEE;
        cyc(1);
        wr_valid = 1'b0;
        vectors++;
        if (fill_count !== 5'd16) begin
            errors++;
            $display("FAIL overflow_ignored: fill=%0d want 16", fill_count);
        end
        enable = 1'b1;
        cyc(2);
        vectors++;
        if (playing !== 1'b1) begin
            errors++;
            $display("FAIL wrap_play: got %b want 1", playing);
        end
        for (int n = 1; n <= 13; n++) begin
            cyc(4);
            vectors++;
            if (dut.cur_sample !== 8'(n)) begin
                errors++;
                $display("FAIL pop_seq[%0d]: cur=%h want %h", n, dut.cur_sample, 8'(n));
            end
        end
        vectors++;
        if (fill_count !== 5'd3) begin
            errors++;
            $display("FAIL fill3: fill=%0d want 3", fill_count);
        end
        cyc(3);
        wr_valid = 1'b1; wr_data = 8'hA0;
        cyc(1);
        wr_valid = 1'b0;
        vectors++;
        if (fill_count !== 5'd3 || dut.cur_sample !== 8'h0E) begin
            errors++;
            $display("FAIL push_pop: fill=%0d cur=%h, want 3 0e", fill_count, dut.cur_sample);
        end
        cyc(4);
        vectors++;
        if (dut.cur_sample !== 8'h0F) begin
            errors++;
            $display("FAIL pop14: cur=%h want 0f", dut.cur_sample);
        end
        cyc(4);
        vectors++;
        if (dut.cur_sample !== 8'h10) begin
            errors++;
            $display("FAIL pop15: cur=%h want 10", dut.cur_sample);
        end
        cyc(4);
        vectors++;
        if (dut.cur_sample !== 8'hA0 || fill_count !== 5'd0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL pop_wrap: cur=%h fill=%0d uf=%b, want a0 0 0", dut.cur_sample, fill_count, underflow);
        end
        enable = 1'b0;
        cyc(1);
    endtask

    task automatic test_volume();
        logic [7:0] exp_cur;
        int         exp_high;
        int         high;
`ifdef AUDIO_STREAM_PLAYER_VOLUME_EN
        exp_cur = 8'h32;
        exp_high = 50;
`else
        exp_cur = 8'hC8;
        exp_high = 200;
`endif
        do_reset();
        volume = 3'd2; wr_data = 8'hC8; wr_valid = 1'b1; enable = 1'b1;
        cyc(7);
        vectors++;
        if (dut.cur_sample !== exp_cur) begin
            errors++;
            $display("FAIL volume_cur: cur=%h want %h", dut.cur_sample, exp_cur);
        end
        cyc(2);
        high = 0;
        for (int i = 0; i < 256; i++) begin
            cyc(1);
            if (pwm_out === 1'b1) high++;
        end
        vectors++;
        if (high !== exp_high) begin
            errors++;
            $display("FAIL pwm_duty: high=%0d want %0d", high, exp_high);
        end
        vectors++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL volume_no_underrun: uf=%b want 0", underflow);
        end
        wr_valid = 1'b0; enable = 1'b0; volume = '0;
        cyc(1);
    endtask

    task automatic test_reset_mid_play();
        do_reset();
        wr_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_data = 8'(8'h40 + i);
            cyc(1);
        end
        wr_valid = 1'b0;
        enable = 1'b1;
        cyc(2);
        cyc(4);
        vectors++;
        if (fill_count !== 5'd5 || playing !== 1'b1 || dut.cur_sample !== 8'h40) begin
            errors++;
            $display("FAIL pre_reset: fill=%0d play=%b cur=%h, want 5 1 40", fill_count, playing, dut.cur_sample);
        end
        #3 reset_n = 1'b0;
        #1;
        vectors++;
        if (fill_count !== 5'd0 || wr_ready !== 1'b1 || underflow !== 1'b0 ||
            playing !== 1'b0 || pwm_out !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: fill=%0d rdy=%b uf=%b play=%b pwm=%b, want 0 1 0 0 0",
                     fill_count, wr_ready, underflow, playing, pwm_out);
        end
        vectors++;
        if (dut.cur_sample !== 8'h80 || dut.pwm_cnt !== 8'd0 || dut.rate_cnt !== 2'd0) begin
            errors++;
            $display("FAIL async_reset_int: cur=%h pwm_cnt=%0d rate=%0d, want 80 0 0",
                     dut.cur_sample, dut.pwm_cnt, dut.rate_cnt);
        end
        enable = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
    endtask

    initial begin
        test_reset();
        test_play_underflow();
        test_full_and_wrap();
        test_volume();
        test_reset_mid_play();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, want completion");
        $fatal(1, "watchdog");
    end
endmodule
